// File: rtl/insmem_defs.sv
// Shared definitions for the instruction-memory write path: loader states,
// word geometry and the big-endian beat-to-byte-lane mapping.
package insmem_defs;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_FULL   = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  // Beat 0 carries the most significant byte (lowest address).
  localparam logic [1:0] BEAT_MSB = 2'd0;
  localparam logic [1:0] BEAT_LSB = 2'd3;

  function automatic int lane_lsb(input logic [1:0] beat);
    return 8 * (BYTES_PER_WORD - 1 - int'(beat));
  endfunction

endpackage

// File: rtl/ins_byte_serializer.sv
// Selects the byte of a 32-bit instruction word presented on a given write beat.
module ins_byte_serializer
  import insmem_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  idx,
  output logic [7:0]  byte_o
);

  assign byte_o = word[lane_lsb(idx) +: 8];

endmodule

// File: rtl/instruction_loader.sv
// Run-time instruction store programmer: takes 32-bit words over valid/ready and
// writes them as four big-endian byte beats at an auto-incrementing address.
module instruction_loader
  import insmem_defs::*;
#(
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 7,
  parameter int BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              InsValid,
  input  logic [31:0]       InsWord,
  output logic              InsReady,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemData,
  output logic [ADDR_W-2:0] WordCount,
  output logic              Busy,
  output logic              Full,
  output logic              Done,
  output logic              Overflow
);

  // One extra pointer bit so ptr can reach MEM_BYTES without aliasing to 0.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] BASE_PTR  = PTR_W'(BASE_ADDR);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MEM_BYTES - BYTES_PER_WORD);
  localparam logic [PTR_W-1:0] WORD_STEP = PTR_W'(BYTES_PER_WORD);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-2:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [31:0] ser_word;
  logic [1:0]  ser_idx;
  logic [7:0]  ser_byte;

  // Beat 0 comes straight from the incoming word; later beats from the latched copy.
  assign ser_word = (state_q == S_WRITE) ? word_q : InsWord;
  assign ser_idx  = (state_q == S_WRITE) ? idx_q + 2'd1 : BEAT_MSB;

  ins_byte_serializer u_ser (
    .word   (ser_word),
    .idx    (ser_idx),
    .byte_o (ser_byte)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    if (Start) begin
      state_d = S_ACCEPT;
      idx_d   = BEAT_MSB;
      ptr_d   = BASE_PTR;
      cnt_d   = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (InsValid) begin
            word_d  = InsWord;
            idx_d   = BEAT_MSB;
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = ADDR_W'(ptr_q + PTR_W'(ser_idx));
            data_d  = ser_byte;
          end else if (Stop) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        S_WRITE: begin
          if (idx_q != BEAT_LSB) begin
            idx_d  = ser_idx;
            we_d   = 1'b1;
            addr_d = ADDR_W'(ptr_q + PTR_W'(ser_idx));
            data_d = ser_byte;
          end else begin
            ptr_d   = ptr_q + WORD_STEP;
            cnt_d   = cnt_q + (ADDR_W-1)'(1);
            state_d = (ptr_q == LAST_PTR) ? S_FULL : S_ACCEPT;
          end
        end
        S_FULL: begin
          if (InsValid) ovf_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= BEAT_MSB;
      ptr_q   <= BASE_PTR;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign InsReady  = (state_q == S_ACCEPT);
  assign Busy      = (state_q == S_WRITE);
  assign Full      = (state_q == S_FULL);
  assign MemWE     = we_q;
  assign MemAddr   = addr_q;
  assign MemData   = data_q;
  assign WordCount = cnt_q;
  assign Done      = done_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed scenarios plus randomized
// word streams checked against a byte-level memory write model.
module tb_instruction_loader;

  localparam int MEM_BYTES = 128;
  localparam int ADDR_W    = 7;
  localparam int BASE_ADDR = 0;
  localparam int WORDS     = MEM_BYTES / 4;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic              Stop = 1'b0;
  logic              InsValid = 1'b0;
  logic [31:0]       InsWord = '0;
  logic              InsReady;
  logic              MemWE;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemData;
  logic [ADDR_W-2:0] WordCount;
  logic              Busy, Full, Done, Overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } beat_t;
  beat_t wr_q[$];

  instruction_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Stop(Stop),
    .InsValid(InsValid), .InsWord(InsWord), .InsReady(InsReady),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemData(MemData), .WordCount(WordCount),
    .Busy(Busy), .Full(Full), .Done(Done), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Observed write log: every byte the memory would actually receive.
  always @(negedge CLK)
    if (!Reset && MemWE) wr_q.push_back('{int'(MemAddr), int'(MemData), cyc});

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Offers a word and returns one cycle after the accept edge (beat 0 visible).
  task automatic send_word(input logic [31:0] w, input logic with_stop);
    int t;
    t = 0;
    InsValid = 1'b1;
    InsWord  = w;
    Stop     = with_stop;
    while (!InsReady && t < 20) begin
      tick();
      t++;
    end
    n_checks++;
    if (InsReady !== 1'b1) begin
      n_fail++;
      $display("FAIL send_word_ready: InsReady=%0b after %0d cycles, required 1", InsReady, t);
    end
    tick();
    InsValid = 1'b0;
    Stop     = 1'b0;
    InsWord  = $urandom;
  endtask

  task automatic test_reset();
    logic [24:0] outs;
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Start = 1'($urandom); Stop = 1'($urandom); InsValid = 1'($urandom); InsWord = $urandom;
      tick();
      outs = {MemWE, MemAddr, MemData, WordCount, Busy, Full, Done, Overflow, InsReady};
      n_checks++;
      if (outs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h, required 0", outs);
      end
    end
    Start = 1'b0; Stop = 1'b0; InsValid = 1'b0;
    Reset = 1'b0;
    tick();
    Start = 1'b1;
    n_checks++;
    if (InsReady !== 1'b0) begin
      n_fail++;
      $display("FAIL start_cycle_ready: got %0b, required 0", InsReady);
    end
    tick();
    Start = 1'b0;
    n_checks++;
    if (InsReady !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_start: got %0b, required 1", InsReady);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    int bad;
    w = 32'h8C22_0004;
    do_start();
    wr_q.delete();
    send_word(w, 1'b0);
    n_checks++;
    if ({MemWE, Busy, MemAddr, MemData} !== {1'b1, 1'b1, 7'(BASE_ADDR), 8'h8C}) begin
      n_fail++;
      $display("FAIL first_beat_latency: we=%0b busy=%0b addr=%0d data=%h, required 1 1 %0d 8c",
               MemWE, Busy, MemAddr, MemData, BASE_ADDR);
    end
    tick(4);
    n_checks++;
    if ({WordCount, InsReady, MemWE, Busy} !== {6'd1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_word_end: cnt=%0d rdy=%0b we=%0b busy=%0b, required 1 1 0 0",
               WordCount, InsReady, MemWE, Busy);
    end
    n_checks++;
    if ({MemAddr, MemData} !== {7'(BASE_ADDR + 3), 8'h04}) begin
      n_fail++;
      $display("FAIL single_word_hold: addr=%0d data=%h, required %0d 04", MemAddr, MemData, BASE_ADDR + 3);
    end
    bad = (wr_q.size() == 4) ? 0 : 1;
    for (int k = 0; k < 4 && bad == 0; k++)
      if (wr_q[k].addr != BASE_ADDR + k || wr_q[k].data != int'((w >> (24 - 8*k)) & 32'hFF) ||
          wr_q[k].cyc != wr_q[0].cyc + k) bad = 1;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL single_word_beats: %0d beats logged (or wrong addr/data/timing), required 4 consecutive", wr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    do_start();
    wr_q.delete();
    for (int i = 0; i < WORDS; i++) send_word(32'(i) * 32'h0101_0101, 1'b0);
    tick(4);
    n_checks++;
    if ({Full, WordCount, InsReady} !== {1'b1, 6'(WORDS), 1'b0}) begin
      n_fail++;
      $display("FAIL fill_state: full=%0b cnt=%0d rdy=%0b, required 1 %0d 0", Full, WordCount, InsReady, WORDS);
    end
    bad = (wr_q.size() == MEM_BYTES) ? 0 : 1;
    for (int j = 0; j < MEM_BYTES && bad == 0; j++)
      if (wr_q[j].addr != BASE_ADDR + j || wr_q[j].data != j / 4) bad = 1;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL fill_bytes: %0d beats logged or content wrong, required %0d ending at addr %0d",
               wr_q.size(), MEM_BYTES, MEM_BYTES - 1);
    end
    n_checks++;
    if (wr_q.size() == MEM_BYTES && wr_q[MEM_BYTES-1].cyc - wr_q[0].cyc != (WORDS - 1) * 5 + 3) begin
      n_fail++;
      $display("FAIL fill_throughput: span %0d cycles, required %0d",
               wr_q[MEM_BYTES-1].cyc - wr_q[0].cyc, (WORDS - 1) * 5 + 3);
    end
    InsValid = 1'b1;
    tick(3);
    InsValid = 1'b0;
    tick();
    n_checks++;
    if ({Overflow, Full, MemWE} !== 3'b110 || wr_q.size() != MEM_BYTES) begin
      n_fail++;
      $display("FAIL overflow: ovf=%0b full=%0b we=%0b beats=%0d, required 1 1 0 %0d",
               Overflow, Full, MemWE, wr_q.size(), MEM_BYTES);
    end
    do_start();
    n_checks++;
    if ({Full, Overflow, InsReady, WordCount} !== {1'b0, 1'b0, 1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL restart_from_full: full=%0b ovf=%0b rdy=%0b cnt=%0d, required 0 0 1 0",
               Full, Overflow, InsReady, WordCount);
    end
  endtask

  task automatic test_abort();
    do_start();
    wr_q.delete();
    send_word(32'h2008_0005, 1'b0);
    tick(2);
    n_checks++;
    if ({MemWE, MemAddr, MemData} !== {1'b1, 7'(BASE_ADDR + 2), 8'h00}) begin
      n_fail++;
      $display("FAIL abort_beat2: we=%0b addr=%0d data=%h, required 1 %0d 00", MemWE, MemAddr, MemData, BASE_ADDR + 2);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n_checks++;
    if ({InsReady, MemWE, Busy, WordCount} !== {1'b1, 1'b0, 1'b0, 6'd0} || wr_q.size() != 3) begin
      n_fail++;
      $display("FAIL abort_state: rdy=%0b we=%0b busy=%0b cnt=%0d beats=%0d, required 1 0 0 0 3",
               InsReady, MemWE, Busy, WordCount, wr_q.size());
    end
    send_word(32'h1234_5678, 1'b0);
    n_checks++;
    if ({MemAddr, MemData} !== {7'(BASE_ADDR), 8'h12}) begin
      n_fail++;
      $display("FAIL abort_ptr_rewind: addr=%0d data=%h, required %0d 12", MemAddr, MemData, BASE_ADDR);
    end
    tick(4);
  endtask

  task automatic test_stop_idle();
    do_start();
    wr_q.delete();
    send_word(32'hCAFE_F00D, 1'b0);
    send_word(32'h0BAD_BEEF, 1'b0);
    tick(4);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    n_checks++;
    if ({Done, InsReady, Busy, WordCount} !== {1'b1, 1'b0, 1'b0, 6'd2} || wr_q.size() != 8) begin
      n_fail++;
      $display("FAIL stop_done: done=%0b rdy=%0b busy=%0b cnt=%0d beats=%0d, required 1 0 0 2 8",
               Done, InsReady, Busy, WordCount, wr_q.size());
    end
    InsValid = 1'b1;
    tick(3);
    InsValid = 1'b0;
    tick();
    n_checks++;
    if ({Overflow, Done, InsReady, WordCount} !== {1'b0, 1'b1, 1'b0, 6'd2} || wr_q.size() != 8) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: ovf=%0b done=%0b rdy=%0b cnt=%0d beats=%0d, required 0 1 0 2 8",
               Overflow, Done, InsReady, WordCount, wr_q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] words[$];
    int n, bad;
    for (int r = 0; r < 6; r++) begin
      do_start();
      wr_q.delete();
      words.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        InsValid = 1'b0;
        tick($urandom_range(0, 3));
        words.push_back($urandom);
        send_word(words[i], 1'($urandom));
        // Stop during the write phase must have no effect.
        Stop = 1'($urandom);
        tick();
        Stop = 1'b0;
      end
      tick(3);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      n_checks++;
      if ({Done, Overflow, InsReady, WordCount} !== {1'b1, 1'b0, 1'b0, 6'(n)}) begin
        n_fail++;
        $display("FAIL random_end_state round %0d: done=%0b ovf=%0b rdy=%0b cnt=%0d, required 1 0 0 %0d",
                 r, Done, Overflow, InsReady, WordCount, n);
      end
      bad = (wr_q.size() == 4 * n) ? 0 : 1;
      for (int j = 0; j < 4 * n && bad == 0; j++)
        if (wr_q[j].addr != BASE_ADDR + j ||
            wr_q[j].data != int'((words[j / 4] >> (24 - 8 * (j % 4))) & 32'hFF) ||
            (j % 4 != 0 && wr_q[j].cyc != wr_q[j-1].cyc + 1)) bad = 1;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random_bytes round %0d: %0d beats logged or content wrong, required %0d", r, wr_q.size(), 4 * n);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [24:0] outs;
    do_start();
    send_word(32'hDEAD_BEEF, 1'b0);
    tick();
    n_checks++;
    if ({MemWE, MemAddr} !== {1'b1, 7'(BASE_ADDR + 1)}) begin
      n_fail++;
      $display("FAIL pre_reset_beat1: we=%0b addr=%0d, required 1 %0d", MemWE, MemAddr, BASE_ADDR + 1);
    end
    #2 Reset = 1'b1;
    #1;
    outs = {MemWE, MemAddr, MemData, WordCount, Busy, Full, Done, Overflow, InsReady};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %h, required 0", outs);
    end
    #3 Reset = 1'b0;
    tick();
    n_checks++;
    if ({InsReady, WordCount, MemWE} !== {1'b0, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL after_async_reset: rdy=%0b cnt=%0d we=%0b, required 0 0 0", InsReady, WordCount, MemWE);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_stop_idle();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
